rgb_out_driver: RTL and testbench
=================================

Name: rgb_out_driver

Overview:
Output-side partner of the switch/button RGB capture block. It accepts a 3-bit colour code over a valid/ready handshake and drives the three LED pins with PWM. Colour changes are cross-faded: the old colour fades down, then the new colour fades up. It sits between the capture block's RGB output and the board LED pins.

Parameters:
BW, 4, brightness/PWM width; MAX_LEVEL = 2^BW-1
STEP_DIV, 8, clock cycles per brightness step (>=1)

Ports:
clk  in  1  system clock
clr  in  1  asynchronous, active-high reset
rgb_in  in  3  colour code; [2]=R, [1]=G, [0]=B
rgb_valid  in  1  rgb_in valid
rgb_ready  out  1  block can accept a code
led  out  3  PWM LED drive, same bit mapping as rgb_in
level  out  BW  current brightness level
busy  out  1  fade in progress

Behaviour:
- One clock, clk. Reset clr is asynchronous, active-high. Asserting clr at any time, including mid-fade, immediately forces: state OFF, color_q=0, pending_q=0, level=0, pwm_cnt=0, step_cnt=0, led=0, rgb_ready=1, busy=0.
- Transfer: occurs on a rising edge when rgb_valid && rgb_ready. rgb_ready is 1 in OFF and ON, and 0 in FADE_UP and FADE_DOWN. While rgb_ready=0, rgb_valid is ignored; the source holds its code.
- busy: 1 exactly in FADE_UP and FADE_DOWN.
- OFF state:
  - Accept of a nonzero code: color_q<=code, go to FADE_UP.
  - Accept of 000: accepted, no state change.
- FADE_UP: step_cnt counts 0..STEP_DIV-1. At STEP_DIV-1, step_cnt wraps to 0 and level increments. When level reaches MAX_LEVEL, go to ON. Total duration is MAX_LEVEL*STEP_DIV cycles.
- ON state:
  - Accept of a code equal to color_q: no-op.
  - Accept of any other code: pending_q<=code, go to FADE_DOWN.
- FADE_DOWN: level decrements once per STEP_DIV cycles. When level reaches 0:
  - pending_q!=0: color_q<=pending_q, go to FADE_UP.
  - pending_q==0: color_q<=0, go to OFF.
- step_cnt clears to 0 on every state entry.
- PWM:
  - pwm_cnt is a free-running BW-bit counter that wraps MAX_LEVEL->0.
  - led[i] is registered: led[i] <= color_q[i] && (pwm_cnt < level). This gives one cycle of latency.
  - level 0 means fully dark. level MAX_LEVEL gives duty MAX_LEVEL/2^BW (15/16 at default).
- level never wraps: it saturates at 0 and MAX_LEVEL by construction.

Optional Feature:
RGB_OUT_GAMMA_EN:
- Defined: the PWM compare uses eff=(level*level)>>BW, i.e. led[i] <= color_q[i] && (pwm_cnt < eff). The product is 2*BW bits wide. At default, level 15 gives eff 14, level 8 gives eff 4, levels 1..3 give eff 0.
- Undefined: linear compare against level.
- Handshake, state timing and the level port are identical in both builds.

Decomposition:
- Package rgb_pkg holds:
  - state enum {OFF, FADE_UP, ON, FADE_DOWN}
  - colour constants: RGB_BLACK=000, RGB_RED=100, RGB_GREEN=010, RGB_BLUE=001, RGB_WHITE=111
  - bit-index constants R_IDX=2, G_IDX=1, B_IDX=0
- One sub-module, rgb_pwm_gen: pwm_cnt plus the compare (optional gamma), producing the registered led[2:0] from color_q and level.
- The FSM, step counter and handshake stay in the top module.

Test Plan:
1. Fade-up from OFF (BW=4, STEP_DIV=8): send 101 -> rgb_ready=0 and busy=1 for 120 cycles, level ramps 0..15, then ON. After that, led[2] and led[0] are high 15 of every 16 cycles and led[1]=0.
2. Same-colour code in ON (101 showing): send 101 -> accepted in one cycle, no fade, busy stays 0, level stays 15.
3. Cross-fade: ON 101, send 010 -> 120 cycles of fade-down to level 0, then 120 cycles of fade-up. rgb_ready=0 for 240 cycles, and rgb_valid asserted during that window is ignored. Afterwards only led[1] toggles.
4. Black code: ON 111, send 000 -> fade-down over 120 cycles, then OFF with color_q=0, led=000 constant and rgb_ready=1.
5. Mid-fade duty and reset: during fade-up at level 8, led[R] is high for 8 of 16 cycles (4 of 16 with RGB_OUT_GAMMA_EN). Pulsing clr at that point drives led=000, level=0 and rgb_ready=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rgb_pkg.sv
// Shared types and constants for the RGB LED output driver.
package rgb_pkg;

  typedef enum logic [1:0] {
    OFF       = 2'd0,
    FADE_UP   = 2'd1,
    ON        = 2'd2,
    FADE_DOWN = 2'd3
  } rgb_state_e;

  localparam logic [2:0] RGB_BLACK = 3'b000;
  localparam logic [2:0] RGB_RED   = 3'b100;
  localparam logic [2:0] RGB_GREEN = 3'b010;
  localparam logic [2:0] RGB_BLUE  = 3'b001;
  localparam logic [2:0] RGB_WHITE = 3'b111;

  localparam int R_IDX = 2;
  localparam int G_IDX = 1;
  localparam int B_IDX = 0;
  localparam int NUM_LANES = 3;

  typedef struct packed {
    logic       valid;
    logic [2:0] code;
  } rgb_req_t;

endpackage

// File: rtl/rgb_pwm_gen.sv
// Free-running PWM counter and per-channel compare producing registered LED drive.
// Optional build macro RGB_OUT_GAMMA_EN squares the level before the compare.
module rgb_pwm_gen
  import rgb_pkg::*;
#(
  parameter int BW = 4
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [NUM_LANES-1:0] color,
  input  logic [BW-1:0]        level,
  output logic [NUM_LANES-1:0] led
);

  logic [BW-1:0]        pwm_cnt_q, pwm_cnt_d;
  logic [BW-1:0]        thr;
  logic [NUM_LANES-1:0] led_q, led_d;

`ifdef RGB_OUT_GAMMA_EN
  logic [2*BW-1:0] lvl_sq;
  always_comb begin
    lvl_sq = {{BW{1'b0}}, level} * {{BW{1'b0}}, level};
    thr    = lvl_sq[2*BW-1:BW];
  end
`else
  always_comb thr = level;
`endif

  // counter wraps MAX_LEVEL->0 through natural BW-bit overflow
  always_comb pwm_cnt_d = pwm_cnt_q + 1'b1;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    always_comb led_d[i] = color[i] && (pwm_cnt_q < thr);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pwm_cnt_q <= '0;
      led_q     <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      led_q     <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: rtl/rgb_out_driver.sv
// Handshaked colour input with cross-faded PWM LED output.
// Build macro RGB_OUT_GAMMA_EN selects the gamma-corrected PWM compare.
module rgb_out_driver
  import rgb_pkg::*;
#(
  parameter int BW       = 4,
  parameter int STEP_DIV = 8
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [2:0]    rgb_in,
  input  logic          rgb_valid,
  output logic          rgb_ready,
  output logic [2:0]    led,
  output logic [BW-1:0] level,
  output logic          busy
);

  localparam int            SW        = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);
  localparam logic [BW-1:0] MAX_LEVEL = '1;

  rgb_state_e    state_q, state_d;
  logic [2:0]    color_q, color_d;
  logic [2:0]    pending_q, pending_d;
  logic [BW-1:0] level_q, level_d;
  logic [SW-1:0] step_q, step_d;
  rgb_req_t      req;
  logic          accept;
  logic          step_tick;

  always_comb begin
    req.valid = rgb_valid;
    req.code  = rgb_in;
    rgb_ready = (state_q == OFF) || (state_q == ON);
    busy      = (state_q == FADE_UP) || (state_q == FADE_DOWN);
    accept    = req.valid && rgb_ready;
    step_tick = (step_q == STEP_LAST);
  end

  always_comb begin
    state_d   = state_q;
    color_d   = color_q;
    pending_d = pending_q;
    level_d   = level_q;
    step_d    = step_q;
    unique case (state_q)
      OFF: begin
        if (accept && (req.code != RGB_BLACK)) begin
          color_d = req.code;
          state_d = FADE_UP;
          step_d  = '0;
        end
      end
      FADE_UP: begin
        if (step_tick) begin
          step_d = '0;
          if (level_q != MAX_LEVEL) level_d = level_q + 1'b1;
          if (level_d == MAX_LEVEL) state_d = ON;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      ON: begin
        if (accept && (req.code != color_q)) begin
          pending_d = req.code;
          state_d   = FADE_DOWN;
          step_d    = '0;
        end
      end
      FADE_DOWN: begin
        if (step_tick) begin
          step_d = '0;
          if (level_q != '0) level_d = level_q - 1'b1;
          // once dark, either fade the queued colour in or park in OFF
          if (level_d == '0) begin
            if (pending_q != RGB_BLACK) begin
              color_d = pending_q;
              state_d = FADE_UP;
            end else begin
              color_d = RGB_BLACK;
              state_d = OFF;
            end
          end
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      default: state_d = OFF;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= OFF;
      color_q   <= RGB_BLACK;
      pending_q <= RGB_BLACK;
      level_q   <= '0;
      step_q    <= '0;
    end else begin
      state_q   <= state_d;
      color_q   <= color_d;
      pending_q <= pending_d;
      level_q   <= level_d;
      step_q    <= step_d;
    end
  end

  assign level = level_q;

  rgb_pwm_gen #(.BW(BW)) u_pwm (
    .clk   (clk),
    .clr   (clr),
    .color (color_q),
    .level (level_q),
    .led   (led)
  );

endmodule

// File: tb/tb_rgb_out_driver.sv
// Directed self-checking bench for rgb_out_driver (BW=4, STEP_DIV=8).
module tb_rgb_out_driver;

  logic       clk = 1'b0;
  logic       clr;
  logic [2:0] rgb_in;
  logic       rgb_valid;
  logic       rgb_ready;
  logic [2:0] led;
  logic [3:0] level;
  logic       busy;

  int n_chk = 0;
  int n_err = 0;
  int cyc;

`ifdef RGB_OUT_GAMMA_EN
  localparam int ON_HIGHS = 28;
  localparam int EFF8     = 4;
`else
  localparam int ON_HIGHS = 30;
  localparam int EFF8     = 8;
`endif

  rgb_out_driver #(.BW(4), .STEP_DIV(8)) dut (
    .clk       (clk),
    .clr       (clr),
    .rgb_in    (rgb_in),
    .rgb_valid (rgb_valid),
    .rgb_ready (rgb_ready),
    .led       (led),
    .level     (level),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // edges since last reset release; gives the bench its own PWM phase
  always @(posedge clk or posedge clr)
    if (clr) cyc <= 0;
    else     cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] code);
    @(negedge clk);
    rgb_in    = code;
    rgb_valid = 1'b1;
    @(negedge clk);
    rgb_valid = 1'b0;
  endtask

  task automatic run_fade(input string tag, input int exp_n, input int probe,
                          input int probe_lvl, input bit inject);
    int n = 0;
    int nrdy = 0;
    while (busy === 1'b1 && n < 1000) begin
      if (n == probe) chk({tag, "_lvl"}, 32'(level), 32'(probe_lvl));
      if (rgb_ready === 1'b0) nrdy++;
      if (inject && n == 10) begin
        rgb_in    = 3'b111;
        rgb_valid = 1'b1;
      end
      if (inject && n == 20) rgb_valid = 1'b0;
      @(negedge clk);
      n++;
    end
    chk({tag, "_len"}, 32'(n), 32'(exp_n));
    chk({tag, "_nrdy"}, 32'(nrdy), 32'(exp_n));
    chk({tag, "_rdy"}, 32'(rgb_ready), 32'd1);
  endtask

  task automatic duty(input string tag, input int er, input int eg, input int eb);
    int r = 0, g = 0, b = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      r += int'(led[2]);
      g += int'(led[1]);
      b += int'(led[0]);
    end
    chk({tag, "_r"}, 32'(r), 32'(er));
    chk({tag, "_g"}, 32'(g), 32'(eg));
    chk({tag, "_b"}, 32'(b), 32'(eb));
  endtask

  initial begin
    clr       = 1'b1;
    rgb_in    = 3'b000;
    rgb_valid = 1'b0;
    #2;
    chk("rst_led",   32'(led), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ready", 32'(rgb_ready), 32'd1);
    chk("rst_busy",  32'(busy), 32'd0);
    #20 clr = 1'b0;

    // 1: fade up magenta from OFF
    send(3'b101);
    run_fade("up101", 120, 64, 8, 1'b0);
    chk("up101_top", 32'(level), 32'd15);
    duty("on101", ON_HIGHS, 0, ON_HIGHS);

    // 2: same colour while ON is a no-op
    send(3'b101);
    chk("same_busy",  32'(busy), 32'd0);
    chk("same_level", 32'(level), 32'd15);
    chk("same_ready", 32'(rgb_ready), 32'd1);

    // 3: cross-fade to green; a held request mid-fade must be ignored
    send(3'b010);
    run_fade("x010", 240, 60, 8, 1'b1);
    chk("x010_top", 32'(level), 32'd15);
    duty("on010", 0, ON_HIGHS, 0);

    // 4: go to white, then black
    send(3'b111);
    run_fade("x111", 240, 120, 0, 1'b0);
    send(3'b000);
    run_fade("dn000", 120, 56, 8, 1'b0);
    chk("off_level", 32'(level), 32'd0);
    chk("off_busy",  32'(busy), 32'd0);
    duty("off", 0, 0, 0);

    // 5: mid-fade duty at level 8, then asynchronous reset
    send(3'b100);
    for (int c = 1; c <= 72; c++) begin
      @(negedge clk);
      if (c == 64) chk("mid_level", 32'(level), 32'd8);
      if (c >= 65) chk("mid_led", 32'(led), ((cyc - 1) % 16 < EFF8) ? 32'd4 : 32'd0);
    end
    clr = 1'b1;
    #1;
    chk("aclr_led",   32'(led), 32'd0);
    chk("aclr_level", 32'(level), 32'd0);
    chk("aclr_ready", 32'(rgb_ready), 32'd1);
    chk("aclr_busy",  32'(busy), 32'd0);
    #2 clr = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_led", 32'(led), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
